// File: rtl/udp_rx.sv
// udp_rx: strips the 8-byte UDP header from an IP payload stream, forwards payload beats.
// Build macro UDP_SRC_PORT_MATCH_EN additionally filters on the source port.
module udp_rx #(
  parameter int DATA_W = 16,
  parameter int LEN_W = 2,
  parameter int PORT_W = 16,
  parameter logic [PORT_W-1:0] DST_PORT = 16'd18000,
  parameter logic [PORT_W-1:0] SRC_PORT = 16'd18000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              cs_err_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              start_o,
  output logic              last_o,
  output logic              abort_o
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HEAD = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  word, word_nxt;
  logic [15:0] remain, remain_nxt;
  logic        drop, drop_nxt;
  logic        first, first_nxt;
  logic        prev_valid;
  logic        src_bad;
  logic        in_data;
  logic        is_last;
  logic [15:0] ulen;
  logic [15:0] beat_len;

`ifdef UDP_SRC_PORT_MATCH_EN
  assign src_bad = (data_i[PORT_W-1:0] != SRC_PORT);
`else
  assign src_bad = 1'b0;
`endif

  assign ulen     = data_i[15:0];
  assign beat_len = 16'(len_i);
  assign in_data  = (state == DATA);
  assign is_last  = in_data & valid_i & (remain <= beat_len);

  assign valid_o = valid_i & in_data & ~drop;
  assign data_o  = data_i;
  assign len_o   = is_last ? remain[LEN_W-1:0] : len_i;
  assign start_o = valid_o & first;
  assign last_o  = valid_o & is_last;
  assign abort_o = cancel_i & in_data & ~drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word       <= 2'd0;
      remain     <= 16'd0;
      drop       <= 1'b0;
      first      <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      word       <= word_nxt;
      remain     <= remain_nxt;
      drop       <= drop_nxt;
      first      <= first_nxt;
      prev_valid <= valid_i;
    end
  end

  always_comb begin
    state_nxt  = state;
    word_nxt   = word;
    remain_nxt = remain;
    drop_nxt   = drop;
    first_nxt  = first;
    unique case (1'b1)
      (state == IDLE): begin
        word_nxt   = 2'd0;
        remain_nxt = 16'd0;
        drop_nxt   = 1'b0;
        first_nxt  = 1'b0;
        // a new packet needs a quiet cycle first, so trailing pad is skipped
        if (valid_i && !prev_valid) begin
          state_nxt = HEAD;
          word_nxt  = 2'd1;
          drop_nxt  = cs_err_i | src_bad;
        end
      end
      (state == HEAD): begin
        if (valid_i) begin
          word_nxt = word + 2'd1;
          unique case (word)
            2'd1: begin
              if (data_i[PORT_W-1:0] != DST_PORT)
                drop_nxt = 1'b1;
            end
            2'd2: begin
              if (ulen < 16'd8) begin
                drop_nxt   = 1'b1;
                remain_nxt = 16'd0;
              end else begin
                remain_nxt = ulen - 16'd8;
              end
            end
            2'd3: begin
              first_nxt = 1'b1;
              state_nxt = (remain != 16'd0) ? DATA : IDLE;
            end
            default: ;
          endcase
        end
      end
      (state == DATA): begin
        if (valid_i) begin
          if (is_last) begin
            state_nxt  = IDLE;
            remain_nxt = 16'd0;
          end else begin
            remain_nxt = remain - beat_len;
          end
          first_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (cancel_i)
      state_nxt = IDLE;
  end

endmodule
